// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-stream frame FIFO: a frame becomes readable only once its
// tlast beat has been accepted; bad (tuser) and, optionally, overflowing frames are discarded whole.
module axis_frame_fifo #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 64,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,

    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,

    output logic                  overflow,
    output logic                  bad_frame,
    output logic                  good_frame
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int MEM_W = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_WRITE,
        ST_DROP
    } wr_state_e;

    wr_state_e        state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_cur_q, wr_ptr_cur_d;
    logic [PTR_W-1:0] rd_ptr_q;

    logic             overflow_q, overflow_d;
    logic             bad_frame_q, bad_frame_d;
    logic             good_frame_q, good_frame_d;

    logic [MEM_W-1:0] mem [DEPTH];
    logic             mem_we;
    logic [MEM_W-1:0] mem_rdata;

    logic [DATA_WIDTH-1:0] out_data_q;
    logic [KEEP_WIDTH-1:0] out_keep_q;
    logic                  out_last_q;
    logic                  out_valid_q;

    logic full;
    logic empty;
    logic wr_ready;
    logic accept;
    logic rd_en;

    // full tracks the in-progress pointer so an uncommitted frame cannot overrun unread data;
    // empty tracks the committed pointer so only complete frames are ever readable
    assign full  = (wr_ptr_cur_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_cur_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign input_axis_tready = wr_ready;
    assign accept            = input_axis_tvalid && wr_ready;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_ptr_cur_d = wr_ptr_cur_q;
        mem_we       = 1'b0;
        overflow_d   = 1'b0;
        bad_frame_d  = 1'b0;
        good_frame_d = 1'b0;
        wr_ready     = 1'b1;

        unique case (state_q)
            ST_WRITE: begin
                wr_ready = (DROP_WHEN_FULL != 0) ? 1'b1 : ~full;
                if (accept) begin
                    if (!full) begin
                        mem_we       = 1'b1;
                        wr_ptr_cur_d = wr_ptr_cur_q + PTR_W'(1);
                        if (input_axis_tlast) begin
                            if (input_axis_tuser) begin
                                wr_ptr_cur_d = wr_ptr_q;
                                bad_frame_d  = 1'b1;
                            end else begin
                                wr_ptr_d     = wr_ptr_cur_q + PTR_W'(1);
                                good_frame_d = 1'b1;
                            end
                        end
                    end else begin
                        // only reachable when dropping on full: rewind and discard the rest
                        wr_ptr_cur_d = wr_ptr_q;
                        if (input_axis_tlast) begin
                            overflow_d = 1'b1;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end

            ST_DROP: begin
                wr_ready = 1'b1;
                if (input_axis_tvalid && input_axis_tlast) begin
                    overflow_d = 1'b1;
                    state_d    = ST_WRITE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_WRITE;
            wr_ptr_q     <= '0;
            wr_ptr_cur_q <= '0;
            overflow_q   <= 1'b0;
            bad_frame_q  <= 1'b0;
            good_frame_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_ptr_cur_q <= wr_ptr_cur_d;
            overflow_q   <= overflow_d;
            bad_frame_q  <= bad_frame_d;
            good_frame_q <= good_frame_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_ptr_cur_q[ADDR_WIDTH-1:0]] <= {input_axis_tlast, input_axis_tkeep, input_axis_tdata};
        end
    end

    assign mem_rdata = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign rd_en     = !empty && (output_axis_tready || !out_valid_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (rd_en) begin
            {out_last_q, out_keep_q, out_data_q} <= mem_rdata;
            out_valid_q <= 1'b1;
            rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        end else if (output_axis_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign output_axis_tdata  = out_data_q;
    assign output_axis_tkeep  = out_keep_q;
    assign output_axis_tlast  = out_last_q;
    assign output_axis_tvalid = out_valid_q;

    assign overflow   = overflow_q;
    assign bad_frame  = bad_frame_q;
    assign good_frame = good_frame_q;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Bench for axis_frame_fifo: directed vector table plus multi-cycle sequences on a
// backpressuring instance (a_*) and a drop-when-full instance (b_*), both 16 deep.
module tb_axis_frame_fifo;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int KW = 8;

    typedef logic [72:0] beat_t;  // {last, keep, data}

    typedef struct {
        logic          v;
        logic [63:0]   d;
        logic [7:0]    k;
        logic          l;
        logic          u;
        logic          ordy;
        logic          e_rdy;
        logic          e_ov;
        logic [63:0]   e_d;
        logic [7:0]    e_k;
        logic          e_ol;
        logic          e_good;
        logic          e_bad;
        logic          e_ovf;
        logic          cd;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [DW-1:0] a_tdata;  logic [KW-1:0] a_tkeep;
    logic a_tvalid, a_tready, a_tlast, a_tuser;
    logic [DW-1:0] a_odata;  logic [KW-1:0] a_okeep;
    logic a_ovalid, a_oready, a_olast, a_ovf, a_bad, a_good;
    logic a_oready_man, rand_rdy, rr;

    logic [DW-1:0] b_tdata;  logic [KW-1:0] b_tkeep;
    logic b_tvalid, b_tready, b_tlast, b_tuser;
    logic [DW-1:0] b_odata;  logic [KW-1:0] b_okeep;
    logic b_ovalid, b_oready, b_olast, b_ovf, b_bad, b_good;

    int tests = 0;
    int fails = 0;
    beat_t a_got[$];
    beat_t a_exp[$];
    beat_t b_got[$];
    int n_good = 0;
    int n_bad  = 0;

    axis_frame_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DROP_WHEN_FULL(0)) dut_a (
        .clk(clk), .rst(rst),
        .input_axis_tdata(a_tdata), .input_axis_tkeep(a_tkeep), .input_axis_tvalid(a_tvalid),
        .input_axis_tready(a_tready), .input_axis_tlast(a_tlast), .input_axis_tuser(a_tuser),
        .output_axis_tdata(a_odata), .output_axis_tkeep(a_okeep), .output_axis_tvalid(a_ovalid),
        .output_axis_tready(a_oready), .output_axis_tlast(a_olast),
        .overflow(a_ovf), .bad_frame(a_bad), .good_frame(a_good)
    );

    axis_frame_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DROP_WHEN_FULL(1)) dut_b (
        .clk(clk), .rst(rst),
        .input_axis_tdata(b_tdata), .input_axis_tkeep(b_tkeep), .input_axis_tvalid(b_tvalid),
        .input_axis_tready(b_tready), .input_axis_tlast(b_tlast), .input_axis_tuser(b_tuser),
        .output_axis_tdata(b_odata), .output_axis_tkeep(b_okeep), .output_axis_tvalid(b_ovalid),
        .output_axis_tready(b_oready), .output_axis_tlast(b_olast),
        .overflow(b_ovf), .bad_frame(b_bad), .good_frame(b_good)
    );

    always begin
        @(posedge clk);
        #1;
        rr = 1'($urandom_range(0, 1));
    end
    assign a_oready = rand_rdy ? rr : a_oready_man;

    // Transfers and status pulses are recorded mid-cycle, where all values are stable.
    always @(negedge clk) begin
        if (a_ovalid && a_oready) a_got.push_back({a_olast, a_okeep, a_odata});
        if (b_ovalid && b_oready) b_got.push_back({b_olast, b_okeep, b_odata});
        if (a_good) n_good++;
        if (a_bad)  n_bad++;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic u, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 1) == 0) begin
                a_tvalid = 1'b0;
                @(posedge clk); #1;
            end
        end
        a_tvalid = 1'b1; a_tdata = d; a_tkeep = k; a_tlast = l; a_tuser = u;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (a_tready) begin
                @(posedge clk); #1;
                a_tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        tests++; fails++;
        $display("FAIL send_timeout: tready got 0 expected 1 within 300 cycles");
        a_tvalid = 1'b0;
    endtask

    task automatic wait_a(input int n);
        for (int i = 0; i < 400 && a_got.size() < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic cmp_q(input string name, input int base);
        chk({name, "_count"}, 96'(a_got.size() - base), 96'(a_exp.size()));
        for (int i = 0; i < a_exp.size() && base + i < a_got.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), 96'(a_got[base + i]), 96'(a_exp[i]));
    endtask

    function automatic vec_t mk(logic v, logic [63:0] d, logic [7:0] k, logic l, logic u,
                                logic ordy, logic er, logic eov, logic [63:0] ed, logic [7:0] ek,
                                logic el, logic eg, logic eb, logic eo, logic cd);
        vec_t r;
        r.v = v; r.d = d; r.k = k; r.l = l; r.u = u; r.ordy = ordy;
        r.e_rdy = er; r.e_ov = eov; r.e_d = ed; r.e_k = ek; r.e_ol = el;
        r.e_good = eg; r.e_bad = eb; r.e_ovf = eo; r.cd = cd;
        return r;
    endfunction

    vec_t vt[$];

    initial begin
        logic [95:0] act, exp;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        int base, j, len, g0, b0, ng, nb;
        bit bad, rdy_ok, ovf_seen, ov_seen;

        rst = 1'b1; rand_rdy = 1'b0; a_oready_man = 1'b1;
        a_tvalid = 0; a_tdata = '0; a_tkeep = '0; a_tlast = 0; a_tuser = 0;
        b_tvalid = 0; b_tdata = '0; b_tkeep = '0; b_tlast = 0; b_tuser = 0; b_oready = 1'b1;

        // v, data, keep, last, user, oready | tready, ovalid, odata, okeep, olast, good, bad, ovf, check-data
        // 3-beat good frame: tuser on a non-last beat is ignored; output valid 2 cycles after tlast
        vt.push_back(mk(1, 64'h1111111111111111, 8'hFF, 0, 0, 1,  1, 0, 64'h0, 8'h00, 0, 0, 0, 0, 1));
        vt.push_back(mk(1, 64'h2222222222222222, 8'hFF, 0, 1, 1,  1, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 64'h3333333333333333, 8'h0F, 1, 0, 1,  1, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 8'h00, 0, 0, 1,                 1, 0, 64'h0, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 8'h00, 0, 0, 1,  1, 1, 64'h1111111111111111, 8'hFF, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 64'h0, 8'h00, 0, 0, 1,  1, 1, 64'h2222222222222222, 8'hFF, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 64'h0, 8'h00, 0, 0, 1,  1, 1, 64'h3333333333333333, 8'h0F, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 64'h0, 8'h00, 0, 0, 1,                 1, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0));
        // 5-beat bad frame then 2-beat good frame: only the good one comes out
        vt.push_back(mk(1, 64'hB0B0B0B0B0B0B0B0, 8'hFF, 0, 0, 1, 1, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 64'hB1B1B1B1B1B1B1B1, 8'hFF, 0, 0, 1, 1, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 64'hB2B2B2B2B2B2B2B2, 8'hFF, 0, 0, 1, 1, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 64'hB3B3B3B3B3B3B3B3, 8'hFF, 0, 0, 1, 1, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 64'hB4B4B4B4B4B4B4B4, 8'hFF, 1, 1, 1, 1, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 64'hA0A0A0A0A0A0A0A0, 8'hFF, 0, 0, 1, 1, 0, 64'h0, 8'h00, 0, 0, 1, 0, 0));
        vt.push_back(mk(1, 64'hA1A1A1A1A1A1A1A1, 8'h3F, 1, 0, 1, 1, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 8'h00, 0, 0, 1,                 1, 0, 64'h0, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 8'h00, 0, 0, 1,  1, 1, 64'hA0A0A0A0A0A0A0A0, 8'hFF, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 64'h0, 8'h00, 0, 0, 1,  1, 1, 64'hA1A1A1A1A1A1A1A1, 8'h3F, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 64'h0, 8'h00, 0, 0, 1,                 1, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            a_tvalid = vt[i].v; a_tdata = vt[i].d; a_tkeep = vt[i].k;
            a_tlast = vt[i].l; a_tuser = vt[i].u; a_oready_man = vt[i].ordy;
            @(negedge clk);
            act = {18'b0, a_tready, a_ovalid, vt[i].cd ? a_odata : 64'h0, vt[i].cd ? a_okeep : 8'h0,
                   vt[i].cd ? a_olast : 1'b0, a_good, a_bad, a_ovf};
            exp = {18'b0, vt[i].e_rdy, vt[i].e_ov, vt[i].cd ? vt[i].e_d : 64'h0,
                   vt[i].cd ? vt[i].e_k : 8'h0, vt[i].cd ? vt[i].e_ol : 1'b0,
                   vt[i].e_good, vt[i].e_bad, vt[i].e_ovf};
            chk($sformatf("vec%0d", i), act, exp);
            @(posedge clk); #1;
        end
        a_tvalid = 1'b0;

        // Drop-when-full: 20-beat frame into 16 entries is discarded, next frame intact
        b_oready = 1'b0; rdy_ok = 1; ovf_seen = 0; ov_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            b_tvalid = 1'b1; b_tdata = 64'(i); b_tkeep = '1; b_tlast = (i == 20); b_tuser = 1'b0;
            @(negedge clk);
            rdy_ok   = rdy_ok & b_tready;
            ovf_seen = ovf_seen | b_ovf;
            ov_seen  = ov_seen | b_ovalid;
            @(posedge clk); #1;
        end
        b_tvalid = 1'b0;
        @(negedge clk);
        chk("dwf_tready_always_high", 96'(rdy_ok), 96'(1));
        chk("dwf_no_early_overflow", 96'(ovf_seen), 96'(0));
        chk("dwf_overflow_pulse", 96'(b_ovf), 96'(1));
        for (int i = 0; i < 5; i++) begin
            ov_seen = ov_seen | b_ovalid;
            @(posedge clk); #1;
            @(negedge clk);
            if (i == 0) chk("dwf_overflow_one_cycle", 96'(b_ovf), 96'(0));
        end
        chk("dwf_output_never_valid", 96'(ov_seen), 96'(0));
        @(posedge clk); #1;
        base = b_got.size(); b_oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_tvalid = 1'b1; b_tdata = 64'h5500 + 64'(i); b_tkeep = 8'hF0 + 8'(i);
            b_tlast = (i == 3); b_tuser = 1'b0;
            @(posedge clk); #1;
        end
        b_tvalid = 1'b0;
        for (int i = 0; i < 40 && b_got.size() < base + 4; i++) begin
            @(posedge clk); #1;
        end
        chk("dwf_next_frame_count", 96'(b_got.size() - base), 96'(4));
        for (int i = 0; i < 4 && base + i < b_got.size(); i++)
            chk($sformatf("dwf_next_beat%0d", i), 96'(b_got[base + i]),
                96'({i == 3, 8'hF0 + 8'(i), 64'h5500 + 64'(i)}));

        // Backpressure: two 10-beat frames with output stalled. 16 beats fit in RAM and
        // one more moves into the output register once frame 1 commits, so 17 are accepted.
        a_oready_man = 1'b0; base = a_got.size(); a_exp.delete(); j = 0;
        for (int c = 0; c < 200 && j < 20; c++) begin
            a_tvalid = 1'b1; a_tkeep = '1; a_tuser = 1'b0;
            a_tdata = (j < 10) ? 64'(256 + j) : 64'(512 + j - 10);
            a_tlast = (j == 9) || (j == 19);
            if (c == 25) begin
                chk("bp_accepted_before_stall", 96'(j), 96'(17));
                chk("bp_tready_low_when_full", 96'(a_tready), 96'(0));
                a_oready_man = 1'b1;
            end
            @(negedge clk);
            if (a_tready) j++;
            @(posedge clk); #1;
        end
        a_tvalid = 1'b0;
        for (int i = 0; i < 20; i++)
            a_exp.push_back({(i == 9) || (i == 19), 8'hFF, (i < 10) ? 64'(256 + i) : 64'(512 + i - 10)});
        wait_a(base + 20);
        cmp_q("bp", base);

        // Random traffic: 200 frames, gaps on both sides, some bad frames; pointers wrap many times
        base = a_got.size(); a_exp.delete(); g0 = n_good; b0 = n_bad; ng = 0; nb = 0;
        rand_rdy = 1'b1;
        for (int f = 0; f < 200; f++) begin
            len = $urandom_range(1, 16);
            bad = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < len; i++) begin
                d = {$urandom, $urandom};
                k = 8'($urandom);
                l = (i == len - 1);
                send_beat(d, k, l, l ? bad : 1'($urandom_range(0, 1)), 1'b1);
                if (!bad) a_exp.push_back({l, k, d});
            end
            if (bad) nb++; else ng++;
        end
        rand_rdy = 1'b0; a_oready_man = 1'b1;
        wait_a(base + a_exp.size());
        repeat (3) @(posedge clk);
        #1;
        cmp_q("rand", base);
        chk("rand_good_pulses", 96'(n_good - g0), 96'(ng));
        chk("rand_bad_pulses", 96'(n_bad - b0), 96'(nb));

        // Reset mid-frame with a committed frame still buffered
        a_oready_man = 1'b0;
        send_beat(64'hC0C0C0C0C0C0C0C0, 8'hFF, 1'b0, 1'b0, 1'b0);
        send_beat(64'hC1C1C1C1C1C1C1C1, 8'hFF, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_pre_valid", 96'(a_ovalid), 96'(1));
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send_beat(64'hD0 + 64'(i), 8'hFF, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        a_tvalid = 1'b1; a_tdata = 64'hDEADDEADDEADDEAD; a_tkeep = '1; a_tlast = 1'b1; a_tuser = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_outputs_zero",
            {18'b0, a_tready, a_ovalid, a_odata, a_okeep, a_olast, a_good, a_bad, a_ovf},
            {18'b0, 1'b1, 77'b0});
        @(posedge clk); #1;
        rst = 1'b0; a_tvalid = 1'b0;
        base = a_got.size(); a_exp.delete(); a_oready_man = 1'b1;
        send_beat(64'hE0E0E0E0E0E0E0E0, 8'hFF, 1'b0, 1'b0, 1'b0);
        send_beat(64'hE1E1E1E1E1E1E1E1, 8'h07, 1'b1, 1'b0, 1'b0);
        a_exp.push_back({1'b0, 8'hFF, 64'hE0E0E0E0E0E0E0E0});
        a_exp.push_back({1'b1, 8'h07, 64'hE1E1E1E1E1E1E1E1});
        wait_a(base + 2);
        repeat (10) @(posedge clk);
        #1;
        cmp_q("post_rst", base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
